// File: rtl/clock_divider_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    localparam int unsigned DefNumCh    = 4;
    localparam int unsigned DefDivWidth = 8;

    // Full divide ratio (clocks per output period) for a divider value.
    function automatic int unsigned div_ratio(input int unsigned div);
        return 2 * (div + 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadowed divider value,
// registered divided clock, edge strobes and activity flag.
module clk_div_channel
    import clock_divider_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DefDivWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 sync,
    output logic                 clk_out,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic                 active
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] shadow_q;
    logic [DIV_WIDTH-1:0] terminal;
    logic                 clk_out_q;
    logic                 rise_q;
    logic                 fall_q;
    logic                 active_q;

    // On the first counting edge after reset or disable the shadow may be stale
    // (reset clears it), so the live divider value sets the first half-period.
    always_comb begin
        terminal = active_q ? shadow_q : div_value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            active_q <= enable;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            if (!enable) begin
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
                shadow_q  <= div_value;
            end else if (sync) begin
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
                shadow_q  <= div_value;
                fall_q    <= clk_out_q;
            end else if (cnt_q == terminal) begin
                cnt_q     <= '0;
                clk_out_q <= ~clk_out_q;
                shadow_q  <= div_value;
                rise_q    <= ~clk_out_q;
                fall_q    <= clk_out_q;
            end else begin
                cnt_q <= cnt_q + DIV_WIDTH'(1);
                if (!active_q) begin
                    shadow_q <= div_value;
                end
            end
        end
    end

    assign clk_out   = clk_out_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign active    = active_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent 50%-duty clock dividers sharing one system clock and a
// common phase-align sync input.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int unsigned NUM_CH    = DefNumCh,
    parameter int unsigned DIV_WIDTH = DefDivWidth
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_value,
    input  logic                        sync,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           rise_tick,
    output logic [NUM_CH-1:0]           fall_tick,
    output logic [NUM_CH-1:0]           active
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable[i]),
            .div_value (div_value[i*DIV_WIDTH +: DIV_WIDTH]),
            .sync      (sync),
            .clk_out   (clk_out[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .active    (active[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: behavioural per-channel model
// checked every cycle, plus table-driven period checks and corner sequences.
module tb_clock_divider_multi;
    import clock_divider_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    enable = '0;
    logic [NCH*DW-1:0] div_value = '0;
    logic              sync = 1'b0;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    rise_tick;
    logic [NCH-1:0]    fall_tick;
    logic [NCH-1:0]    active;

    int checks = 0;
    int errors = 0;

    // Model: each channel counts edges spent in the current half-period and
    // flips when that count reaches the latched half length (div+1).
    logic [NCH-1:0] m_clk = '0, m_rise = '0, m_fall = '0, m_active = '0;
    int m_pos [NCH];
    int m_half[NCH];

    typedef struct {
        int ch;
        int div;
        int period;
    } period_vec_t;

    period_vec_t tab[NCH];

    clock_divider_multi #(
        .NUM_CH    (NCH),
        .DIV_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .div_value (div_value),
        .sync      (sync),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_div(input int ch, input int val);
        div_value[ch*DW +: DW] = DW'(val);
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int d;
            d = int'(div_value[c*DW +: DW]);
            if (reset) begin
                m_clk[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_active[c] = 1'b0;
                m_pos[c] = 0; m_half[c] = 1;
            end else begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (!enable[c]) begin
                    m_clk[c] = 1'b0; m_pos[c] = 0; m_half[c] = d + 1;
                end else if (sync) begin
                    m_fall[c] = m_clk[c];
                    m_clk[c] = 1'b0; m_pos[c] = 0; m_half[c] = d + 1;
                end else begin
                    if (!m_active[c]) m_half[c] = d + 1;
                    m_pos[c] = m_pos[c] + 1;
                    if (m_pos[c] == m_half[c]) begin
                        m_clk[c]  = ~m_clk[c];
                        m_rise[c] = m_clk[c];
                        m_fall[c] = ~m_clk[c];
                        m_pos[c]  = 0;
                        m_half[c] = d + 1;
                    end
                end
                m_active[c] = enable[c];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_clk_out", int'(clk_out), int'(m_clk));
        check("model_rise_tick", int'(rise_tick), int'(m_rise));
        check("model_fall_tick", int'(fall_tick), int'(m_fall));
        check("model_active", int'(active), int'(m_active));
    endtask

    // Returns number of steps until the requested strobe on ch, or -1 on timeout.
    task automatic wait_tick(input int ch, input bit want_rise, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit && n < 0; k++) begin
            step();
            if ((want_rise ? rise_tick[ch] : fall_tick[ch]) == 1'b1) n = k;
        end
    endtask

    task automatic do_reset();
        enable = '0;
        sync   = 1'b0;
        reset  = 1'b1;
        step();
        step();
        reset  = 1'b0;
    endtask

    initial begin
        int n, n2;
        logic [7:0] rise_hist, fall_hist;
        logic [NCH-1:0] others, prev, dbl;
        int last_rise[NCH], meas_period[NCH], meas_high[NCH];

        // Reset, then channel 0 at div=1
        set_div(0, 1);
        do_reset();
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_active", int'(active), 0);
        check("reset_ticks", int'(rise_tick | fall_tick), 0);
        enable = 4'b0001;
        rise_hist = '0; fall_hist = '0; others = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            rise_hist[k] = rise_tick[0];
            fall_hist[k] = fall_tick[0];
            others |= clk_out & 4'b1110;
        end
        check("div1_rise_pattern", int'(rise_hist), 8'b0010_0010);
        check("div1_fall_pattern", int'(fall_hist), 8'b1000_1000);
        check("div1_others_idle", int'(others), 0);

        // Table-driven periods and duty, all channels running
        tab[0] = '{ch: 0, div: 0,  period: 2};
        tab[1] = '{ch: 1, div: 3,  period: 8};
        tab[2] = '{ch: 2, div: 7,  period: 16};
        tab[3] = '{ch: 3, div: 15, period: 32};
        for (int i = 0; i < NCH; i++) set_div(tab[i].ch, tab[i].div);
        do_reset();
        enable = '1;
        for (int i = 0; i < NCH; i++) begin
            last_rise[i] = -1; meas_period[i] = -1; meas_high[i] = -1;
        end
        prev = '0; dbl = '0;
        for (int k = 0; k < 100; k++) begin
            step();
            dbl |= (rise_tick & prev);
            prev = rise_tick;
            for (int i = 0; i < NCH; i++) begin
                if (fall_tick[i] && last_rise[i] >= 0) meas_high[i] = k - last_rise[i];
                if (rise_tick[i]) begin
                    if (last_rise[i] >= 0) meas_period[i] = k - last_rise[i];
                    last_rise[i] = k;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("period_ch%0d", tab[i].ch), meas_period[tab[i].ch], tab[i].period);
            check($sformatf("high_ch%0d", tab[i].ch), meas_high[tab[i].ch],
                  int'(div_ratio(tab[i].div)) / 2);
        end
        check("tick_single_cycle", int'(dbl), 0);

        // Divider change just after a rise only takes effect at the next toggle
        do_reset();
        set_div(0, 3);
        enable = 4'b0001;
        wait_tick(0, 1'b1, 20, n);
        check("chg_first_rise", n, 4);
        step();
        set_div(0, 7);
        wait_tick(0, 1'b0, 20, n);
        check("chg_high_len", n + 1, 4);
        wait_tick(0, 1'b1, 20, n);
        check("chg_low_len", n, 8);

        // Disable while high: drop without fall tick, re-enable restarts
        do_reset();
        set_div(1, 7);
        enable = 4'b0010;
        wait_tick(1, 1'b1, 20, n);
        step();
        enable[1] = 1'b0;
        step();
        check("dis_clk_low", int'(clk_out[1]), 0);
        check("dis_no_fall", int'(fall_tick[1]), 0);
        step();
        step();
        enable[1] = 1'b1;
        wait_tick(1, 1'b1, 20, n);
        check("reen_first_rise", n, 8);

        // Sync from arbitrary phase
        do_reset();
        set_div(0, 3); set_div(1, 3); set_div(2, 7); set_div(3, 7);
        for (int c = 0; c < NCH; c++) begin
            enable[c] = 1'b1;
            n2 = $urandom_range(1, 5);
            for (int k = 0; k < n2; k++) step();
        end
        n2 = $urandom_range(0, 20);
        for (int k = 0; k < n2; k++) step();
        prev = clk_out;
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_clk_low", int'(clk_out), 0);
        check("sync_fall", int'(fall_tick), int'(prev));
        check("sync_no_rise", int'(rise_tick), 0);
        for (int k = 0; k < 4; k++) step();
        check("sync_rise_fast", int'(rise_tick), 4'b0011);
        for (int k = 0; k < 4; k++) step();
        check("sync_rise_slow", int'(rise_tick), 4'b1100);

        // Reset mid-operation with all channels high
        for (int c = 0; c < NCH; c++) set_div(c, 3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("all_high", int'(clk_out), 4'b1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_clk", int'(clk_out), 0);
        check("midrst_ticks", int'(rise_tick | fall_tick), 0);
        check("midrst_active", int'(active), 0);
        wait_tick(0, 1'b1, 20, n);
        check("midrst_restart", n, 4);
        check("midrst_all_rise", int'(rise_tick), 4'b1111);

        // Maximum divider value
        do_reset();
        set_div(2, 255);
        enable = 4'b0100;
        wait_tick(2, 1'b1, 300, n);
        check("max_first_rise", n, 256);
        wait_tick(2, 1'b0, 300, n);
        check("max_half", n, int'(div_ratio(255)) / 2);

        // Randomised traffic against the model
        do_reset();
        enable = '1;
        for (int c = 0; c < NCH; c++) set_div(c, $urandom_range(0, 15));
        for (int k = 0; k < 3000; k++) begin
            int ch;
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 15) == 0) enable[ch] = ~enable[ch];
            if ($urandom_range(0, 7) == 0) set_div(ch, $urandom_range(0, 15));
            sync  = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        sync  = 1'b0;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
